// File: rtl/bcd_pkg.sv
// bcd_pkg: shared defaults and state encoding for the binary-to-BCD converter.
//   ANCHO_DEF    default binary input width (matches multiplier Producto)
//   DIGITOS_DEF  default number of BCD digits produced
//   ESPERA/CONVIRTIENDO/LISTO  FSM state codes (2'd3 is treated as ESPERA)
//   ancho_cnt_w  width of an iteration counter able to hold ANCHO
package bcd_pkg;

  localparam int unsigned ANCHO_DEF   = 17;
  localparam int unsigned DIGITOS_DEF = 6;

  localparam logic [1:0] ESPERA       = 2'd0;
  localparam logic [1:0] CONVIRTIENDO = 2'd1;
  localparam logic [1:0] LISTO        = 2'd2;

  localparam int unsigned CNT_W_DEF = $clog2(ANCHO_DEF + 1);

  function automatic int unsigned ancho_cnt_w(input int unsigned ancho);
    return $clog2(ancho + 1);
  endfunction

endpackage

// File: rtl/ajuste_digito.sv
// ajuste_digito: double-dabble correction for one BCD digit.
//   digito    in  4  scratch digit before the shift
//   ajustado  out 4  digito+3 when digito >= 5, otherwise unchanged
module ajuste_digito (
  input  logic [3:0] digito,
  output logic [3:0] ajustado
);

  always_comb begin
    ajustado = digito;
    if (digito >= 4'd5) ajustado = digito + 4'd3;
  end

endmodule

// File: rtl/bin_a_bcd.sv
// bin_a_bcd: sequential binary-to-BCD converter, one shift-and-add-3
// iteration per clock. Sits downstream of the shift-add multiplier.
//   Clock    in             system clock, rising edge
//   Reset    in             asynchronous, active-low reset
//   Start    in             conversion request (ignored while converting)
//   Binario  in  ANCHO      unsigned value, sampled on the accepting edge
//   Ready    out            BCD holds a completed result and block is idle
//   BCD      out 4*DIGITOS  packed BCD, digit 0 (units) in bits [3:0]
module bin_a_bcd
  import bcd_pkg::*;
#(
  parameter int unsigned ANCHO   = ANCHO_DEF,
  parameter int unsigned DIGITOS = DIGITOS_DEF
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Start,
  input  logic [ANCHO-1:0]       Binario,
  output logic                   Ready,
  output logic [4*DIGITOS-1:0]   BCD
);

  localparam int unsigned CW = ancho_cnt_w(ANCHO);

  logic [1:0]           estado;
  logic [CW-1:0]        cuenta;
  logic [ANCHO-1:0]     desp;
  logic [4*DIGITOS-1:0] scratch;
  logic [4*DIGITOS-1:0] scratch_aj;
  logic [4*DIGITOS-1:0] scratch_nx;
  logic [ANCHO-1:0]     desp_nx;
  logic [4*DIGITOS-1:0] bcd_q;
  logic                 ready_q;

  for (genvar g = 0; g < DIGITOS; g++) begin : g_ajuste
    ajuste_digito u_ajuste (
      .digito   (scratch[4*g +: 4]),
      .ajustado (scratch_aj[4*g +: 4])
    );
  end

  // Shifting the whole {scratch, shift reg} vector drops the scratch MSB,
  // which the algorithm guarantees is zero for valid ANCHO/DIGITOS.
  assign {scratch_nx, desp_nx} = {scratch_aj, desp} << 1;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      estado  <= ESPERA;
      cuenta  <= '0;
      desp    <= '0;
      scratch <= '0;
      bcd_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (estado)
        CONVIRTIENDO: begin
          scratch <= scratch_nx;
          desp    <= desp_nx;
          cuenta  <= cuenta - CW'(1);
          if (cuenta == CW'(1)) begin
            bcd_q   <= scratch_nx;
            ready_q <= 1'b1;
            estado  <= LISTO;
          end
        end
        // ESPERA, LISTO and the unused code all wait for Start.
        default: begin
          if (Start) begin
            desp    <= Binario;
            scratch <= '0;
            cuenta  <= CW'(ANCHO);
            ready_q <= 1'b0;
            estado  <= CONVIRTIENDO;
          end
        end
      endcase
    end
  end

  assign Ready = ready_q;
  assign BCD   = bcd_q;

endmodule
